// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, execute-to-memory bus layout and load_op codes for mem_stage.
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 129;
  localparam int MS_TO_WS_BUS_WD = 123;
  localparam int MS_FWD_BUS_WD = 42;
  // c0_bus is {mtc0, mfc0, eret, c0_addr[7:0]}
  localparam int C0_ERET_BIT = 8;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4,
    LD_WL = 3'd5,
    LD_WR = 3'd6
  } load_op_e;
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [2:0]  load_op;
    logic        mem_req;
    logic [1:0]  addr_low;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: aligns and extends load data; LWL/LWR decode only when MS_LWLR_EN is defined.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  input  logic [3:0]  rf_we_in,
  output logic [31:0] result,
  output logic [3:0]  rf_we
);
  logic [7:0] bsel;
  logic [15:0] hsel;
  assign bsel = rdata[8*addr_low +: 8];
  assign hsel = addr_low[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    result = rdata;
    rf_we = rf_we_in;
    case (load_op)
      LD_B:  result = {{24{bsel[7]}}, bsel};
      LD_BU: result = {24'd0, bsel};
      LD_H:  result = {{16{hsel[15]}}, hsel};
      LD_HU: result = {16'd0, hsel};
`ifdef MS_LWLR_EN
      LD_WL: begin
        result = rdata << {~addr_low, 3'b000};
        rf_we = 4'b1111 << ~addr_low;
      end
      LD_WR: begin
        result = rdata >> {addr_low, 3'b000};
        rf_we = 4'b1111 >> addr_low;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; waits for load data, buffers it under backpressure, drops orphaned responses.
// Define MS_LWLR_EN to build LWL/LWR support.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic                       ms_ex_eret
);
  es_bus_t r;
  logic ms_valid, ms_ready_go, rbuf_valid, discard, is_load, leave, live_ok, catch_rdata;
  logic [31:0] rbuf, ld_result, result;
  logic [3:0] ld_we, rf_we;
  assign live_ok = data_sram_data_ok && !discard;
  assign ms_ready_go = !r.mem_req || r.ex || rbuf_valid || live_ok;
  assign ms_allowin = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign leave = ms_to_ws_valid && ws_allowin;
  assign catch_rdata = live_ok && ms_valid && r.mem_req && !ws_allowin && !rbuf_valid;
  assign is_load = r.mem_req && !r.ex;
  mem_load_align u_align (
    .load_op (r.load_op),
    .addr_low(r.addr_low),
    .rdata   (rbuf_valid ? rbuf : data_sram_rdata),
    .rf_we_in(r.rf_we),
    .result  (ld_result),
    .rf_we   (ld_we)
  );
  assign result = is_load ? ld_result : r.alu_result;
  assign rf_we = is_load ? ld_we : r.rf_we;
  assign ms_to_ws_bus = {r.badvaddr, r.c0_bus, r.bd, r.ex, r.excode, rf_we, r.dest, result, r.pc};
  assign ms_fwd_bus = {ms_valid && r.mem_req && !ms_ready_go, rf_we & {4{ms_valid}}, r.dest, result};
  assign ms_ex_eret = ms_valid && (r.ex || r.c0_bus[C0_ERET_BIT]);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid <= 1'b0;
      r <= '0;
      rbuf_valid <= 1'b0;
      rbuf <= '0;
      discard <= 1'b0;
    end else begin
      ms_valid <= !flush && (ms_allowin ? es_to_ms_valid : ms_valid);
      if (es_to_ms_valid && ms_allowin) r <= es_to_ms_bus;
      rbuf_valid <= !flush && !leave && (rbuf_valid || catch_rdata);
      if (catch_rdata) rbuf <= data_sram_rdata;
      // a flushed load still owes one response; swallow it when it comes
      discard <= data_sram_data_ok ? 1'b0 :
                 discard || (flush && ms_valid && r.mem_req && !r.ex && !rbuf_valid);
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a behavioural load-result model.
module tb_mem_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic es_to_ms_valid = 1'b0, ws_allowin = 1'b0, data_sram_data_ok = 1'b0, flush = 1'b0;
  logic [128:0] es_to_ms_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic ms_allowin, ms_to_ws_valid, ms_ex_eret;
  logic [122:0] ms_to_ws_bus;
  logic [41:0] ms_fwd_bus;
  int checks = 0, failures = 0;
  typedef struct {
    logic [122:0] bus;
    logic ee;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_fwd_bus(ms_fwd_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ms_ex_eret(ms_ex_eret)
  );

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [128:0] mk(input logic [2:0] op, input logic [1:0] a, input logic mreq,
                                      input logic exb, input logic [3:0] we, input logic [31:0] alu);
    logic [31:0] bv, pc;
    logic [10:0] c0;
    logic [4:0] excode, dest;
    bv = $urandom;
    pc = $urandom;
    c0 = 11'($urandom);
    excode = 5'($urandom);
    dest = 5'($urandom);
    return {bv, c0, 1'($urandom), exb, excode, op, mreq, a, we, dest, alu, pc};
  endfunction

  // Expected writeback bus from the instruction fields and the data the memory returns
  function automatic logic [122:0] model(input logic [128:0] b, input logic [31:0] rd);
    logic [31:0] res, w;
    logic [3:0] we;
    logic [3:0] lwl [4];
    logic [3:0] lwr [4];
    int a, op;
    lwl = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    lwr = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    a = int'(b[74:73]);
    op = int'(b[78:76]);
    we = b[72:69];
    res = b[63:32];
    if (b[75] && !b[84]) begin
      res = rd;
      if (op == 1 || op == 2) begin
        w = (rd >> (8 * a)) & 32'hff;
        res = (op == 1 && w >= 32'd128) ? w - 32'd256 : w;
      end
      if (op == 3 || op == 4) begin
        w = (rd >> (16 * (a / 2))) & 32'hffff;
        res = (op == 3 && w >= 32'h8000) ? w - 32'h10000 : w;
      end
`ifdef MS_LWLR_EN
      if (op == 5) begin
        res = rd << (8 * (3 - a));
        we = lwl[a];
      end
      if (op == 6) begin
        res = rd >> (8 * a);
        we = lwr[a];
      end
`endif
    end
    return {b[128:97], b[96:86], b[85], b[84], b[83:79], we, b[68:64], res, b[31:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && ms_to_ws_valid && ws_allowin) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got bus %0h with nothing expected", ms_to_ws_bus);
      end else begin
        e = q.pop_front();
        chk("ws_bus", 128'(ms_to_ws_bus), 128'(e.bus));
        chk("ex_eret", 128'(ms_ex_eret), 128'(e.ee));
        chk("fwd_bus", 128'(ms_fwd_bus), 128'({1'b0, e.bus[72:69], e.bus[68:64], e.bus[63:32]}));
      end
    end
  end

  // Issue one instruction into an empty stage; respond dly cycles after entry, stall writeback for hold cycles
  task automatic run_op(input logic [128:0] b, input logic [31:0] rd, input int dly, input int hold);
    logic needs, given, done;
    exp_t e;
    needs = b[75] && !b[84];
    e.bus = model(b, rd);
    e.ee = b[84] | b[94];
    q.push_back(e);
    chk("allowin_empty", 128'(ms_allowin), 128'(1));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = b;
    data_sram_data_ok = 1'b0;
    step();
    es_to_ms_valid = 1'b0;
    given = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      data_sram_data_ok = needs && k == dly;
      data_sram_rdata = data_sram_data_ok ? rd : $urandom;
      given = given || data_sram_data_ok;
      ws_allowin = k < hold ? 1'b0 : (k > 8 || $urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("out_valid", 128'(ms_to_ws_valid), 128'(!needs || given));
      chk("load_pending", 128'(ms_fwd_bus[41]), 128'(needs && !given));
      done = ms_to_ws_valid && ws_allowin;
      step();
    end
    data_sram_data_ok = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: instruction pc=%0h never left the stage", b[31:0]);
    end
  endtask

  initial begin
    logic [128:0] b, b2;
    exp_t e;
    #10;
    chk("rst_valid", 128'(ms_to_ws_valid), 128'(0));
    chk("rst_bus", 128'(ms_to_ws_bus), 128'(0));
    chk("rst_fwd", 128'(ms_fwd_bus), 128'(0));
    chk("rst_ex_eret", 128'(ms_ex_eret), 128'(0));
    chk("rst_allowin", 128'(ms_allowin), 128'(1));
    #2 reset = 1'b1;
    step();
    run_op(mk(3'd1, 2'd2, 1'b1, 1'b0, 4'hf, $urandom), 32'h11802233, 0, 0);
    run_op(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hf, $urandom), 32'hDEADBEEF, 2, 0);
    run_op(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hf, $urandom), 32'hCAFEF00D, 0, 2);
    // flush while a load waits; its late response must not reach the next load
    b = mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hf, $urandom);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = b;
    ws_allowin = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("flush_wait_pending", 128'(ms_fwd_bus[41]), 128'(1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    b2 = mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hf, $urandom);
    e.bus = model(b2, 32'h5678);
    e.ee = b2[84] | b2[94];
    q.push_back(e);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = b2;
    @(negedge clk);
    chk("flushed_valid", 128'(ms_to_ws_valid), 128'(0));
    chk("flushed_allowin", 128'(ms_allowin), 128'(1));
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234;
    @(negedge clk);
    chk("stale_ignored", 128'(ms_to_ws_valid), 128'(0));
    chk("stale_pending", 128'(ms_fwd_bus[41]), 128'(1));
    step();
    data_sram_rdata = 32'h5678;
    @(negedge clk);
    chk("own_resp_valid", 128'(ms_to_ws_valid), 128'(1));
    step();
    data_sram_data_ok = 1'b0;
    run_op(mk(3'd5, 2'd1, 1'b1, 1'b0, 4'hf, $urandom), 32'hAABBCCDD, 1, 0);
    // asynchronous reset in the middle of a wait
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hf, $urandom);
    ws_allowin = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_pending", 128'(ms_fwd_bus[41]), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 128'(ms_to_ws_valid), 128'(0));
    chk("async_rst_bus", 128'(ms_to_ws_bus), 128'(0));
    chk("async_rst_fwd", 128'(ms_fwd_bus), 128'(0));
    chk("async_rst_ex_eret", 128'(ms_ex_eret), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int i = 0; i < 60; i++)
      run_op(mk(3'($urandom_range(0, 6)), 2'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, 4'($urandom), $urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    step();
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
